// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the two-requester memory port arbiter.
// The optional round-robin tie-break is enabled with ARB_ROUND_ROBIN_EN.
package mem_port_arbiter_pkg;

  // Word-address width of the shared data memory.
  localparam int DATA_MEM_ADDR_SIZE = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Two-way winner selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN: ties go to the requester not granted last; otherwise DATA wins.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   elig_if,
  input  logic   elig_d,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t last_grant,
`endif
  output logic   win_valid,
  output owner_t win_owner
);

  always_comb begin
    win_valid = elig_if | elig_d;
    win_owner = OWN_IF;
    if (elig_d && !elig_if) begin
      win_owner = OWN_DATA;
    end else if (elig_d && elig_if) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_owner = (last_grant == OWN_IF) ? OWN_DATA : OWN_IF;
`else
      // Data first: it belongs to the older instruction in the pipeline.
      win_owner = OWN_DATA;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and data access.
// ARB_ROUND_ROBIN_EN selects alternating tie-break instead of fixed data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DATA_MEM_ADDR_SIZE,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic              if_stall,
  output logic              d_stall
);

  arb_state_t state_reg;
  owner_t     owner_reg;
  logic       is_write_reg;
  logic       elig_if;
  logic       elig_d;
  logic       win_valid;
  owner_t     win_owner;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t     last_grant_reg;
`endif

  // Acks come straight from the registered RESP state, so they pulse exactly once.
  assign if_ack   = (state_reg == ST_RESP) && (owner_reg == OWN_IF);
  assign d_ack    = (state_reg == ST_RESP) && (owner_reg == OWN_DATA);
  assign if_rdata = if_ack ? mem_q : '0;
  assign d_rdata  = (d_ack && !is_write_reg) ? mem_q : '0;
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

  // A requester being acked this cycle cannot win again; reset blocks all grants.
  assign elig_if = rst & if_req & ~if_ack;
  assign elig_d  = rst & d_req & ~d_ack;

  arb_pick u_pick (
    .elig_if    (elig_if),
    .elig_d     (elig_d),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_reg),
`endif
    .win_valid  (win_valid),
    .win_owner  (win_owner)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    if (win_valid) begin
      if (win_owner == OWN_IF) begin
        mem_addr = if_addr;
        mem_rden = 1'b1;
      end else begin
        mem_addr = d_addr;
        if (d_we) begin
          mem_wdata = d_wdata;
          mem_wren  = 1'b1;
        end else begin
          mem_rden = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_IF;
      is_write_reg   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_reg <= OWN_IF;
`endif
    end else if (win_valid) begin
      state_reg      <= ST_RESP;
      owner_reg      <= win_owner;
      is_write_reg   <= (win_owner == OWN_DATA) && d_we;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_reg <= win_owner;
`endif
    end else begin
      state_reg    <= ST_IDLE;
      is_write_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read memory model.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic          mem_rden;
  logic [DW-1:0] mem_q = '0;
  logic          if_stall;
  logic          d_stall;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rden(mem_rden), .mem_q(mem_q),
    .if_stall(if_stall), .d_stall(d_stall)
  );

  always @(posedge clk) begin
    if (!rst) begin
      mem[4] <= 32'h2008_0005;
      mem[8] <= 32'h1111_2222;
    end else begin
      if (mem_wren) mem[mem_addr] <= mem_wdata;
      if (mem_rden) mem_q <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with both requests high: everything quiet.
    if_req = 1'b1; if_addr = 10'h004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h008;
    tick; tick; #1;
    $display("txn reset-hold");
    check("rst_if_ack", {31'b0, if_ack}, 32'd0);
    check("rst_d_ack", {31'b0, d_ack}, 32'd0);
    check("rst_mem_rden", {31'b0, mem_rden}, 32'd0);
    check("rst_mem_wren", {31'b0, mem_wren}, 32'd0);
    check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);

    // Release: data wins the first grant.
    rst = 1'b1; #1;
    $display("txn reset-release data read 0x008");
    check("rel_mem_addr", {22'b0, mem_addr}, 32'h008);
    check("rel_mem_rden", {31'b0, mem_rden}, 32'd1);
    tick;
    if_req = 1'b0; d_req = 1'b0; #1;
    check("rel_d_ack", {31'b0, d_ack}, 32'd1);
    check("rel_d_rdata", d_rdata, 32'h1111_2222);
    check("rel_if_ack", {31'b0, if_ack}, 32'd0);
    tick; #1;
    check("rel_d_ack_drop", {31'b0, d_ack}, 32'd0);

    // Fetch only.
    $display("txn fetch 0x004");
    if_req = 1'b1; if_addr = 10'h004; #1;
    check("if_mem_rden", {31'b0, mem_rden}, 32'd1);
    check("if_mem_addr", {22'b0, mem_addr}, 32'h004);
    check("if_stall_n", {31'b0, if_stall}, 32'd1);
    check("if_ack_n", {31'b0, if_ack}, 32'd0);
    tick; #1;
    check("if_ack_n1", {31'b0, if_ack}, 32'd1);
    check("if_rdata_n1", if_rdata, 32'h2008_0005);
    check("if_stall_n1", {31'b0, if_stall}, 32'd0);
    check("if_no_regrant", {31'b0, mem_rden}, 32'd0);
    if_req = 1'b0;
    tick; #1;
    check("if_ack_n2", {31'b0, if_ack}, 32'd0);
    check("if_rdata_n2", if_rdata, 32'd0);

    // Data write then read back.
    $display("txn write 0x010 0xDEADBEEF");
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'hDEAD_BEEF; #1;
    check("wr_mem_wren", {31'b0, mem_wren}, 32'd1);
    check("wr_mem_rden", {31'b0, mem_rden}, 32'd0);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_d_stall", {31'b0, d_stall}, 32'd1);
    tick; #1;
    check("wr_d_ack", {31'b0, d_ack}, 32'd1);
    check("wr_d_rdata", d_rdata, 32'd0);
    d_we = 1'b0;
    tick; #1;
    $display("txn read 0x010");
    check("rd_mem_rden", {31'b0, mem_rden}, 32'd1);
    check("rd_mem_addr", {22'b0, mem_addr}, 32'h010);
    check("rd_d_ack_n", {31'b0, d_ack}, 32'd0);
    tick; #1;
    check("rd_d_ack", {31'b0, d_ack}, 32'd1);
    check("rd_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick;

    // Contention: grants alternate D, I, D, I ...
    if_req = 1'b1; if_addr = 10'h004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010; #1;
    for (int k = 0; k < 6; k++) begin
      $display("txn contention cycle %0d expect %s", k, (k % 2 == 0) ? "D" : "I");
      check("cont_grant_addr", {22'b0, mem_addr}, (k % 2 == 0) ? 32'h010 : 32'h004);
      check("cont_rden", {31'b0, mem_rden}, 32'd1);
      if (k > 0) begin
        check("cont_d_ack", {31'b0, d_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
        check("cont_if_ack", {31'b0, if_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      tick; #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    tick; tick; #1;

    // Single data requester held: one ack every second cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h008; #1;
    for (int k = 0; k < 6; k++) begin
      $display("txn d-hold cycle %0d", k);
      check("hold_d_ack", {31'b0, d_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check("hold_rden", {31'b0, mem_rden}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k < 5) begin
        tick; #1;
      end
    end
    d_req = 1'b0;
    tick; #1;

    // Reset during RESP aborts without an ack.
    $display("txn mid-access reset");
    if_req = 1'b1; if_addr = 10'h004; #1;
    tick;
    rst = 1'b0; #1;
    check("mrst_if_ack", {31'b0, if_ack}, 32'd0);
    check("mrst_rden", {31'b0, mem_rden}, 32'd0);
    if_req = 1'b0;
    tick;
    rst = 1'b1;
    tick; #1;
    check("mrst_after_ack", {31'b0, if_ack}, 32'd0);
    check("mrst_after_rden", {31'b0, mem_rden}, 32'd0);

    // Flush: request dropped after grant still acks once, no new access.
    $display("txn flush fetch");
    if_req = 1'b1; if_addr = 10'h004; #1;
    check("fl_rden", {31'b0, mem_rden}, 32'd1);
    tick;
    if_req = 1'b0; #1;
    check("fl_if_ack", {31'b0, if_ack}, 32'd1);
    check("fl_if_rdata", if_rdata, 32'h2008_0005);
    check("fl_no_access", {31'b0, mem_rden | mem_wren}, 32'd0);
    tick; #1;
    check("fl_if_ack_drop", {31'b0, if_ack}, 32'd0);
    check("fl_idle_rden", {31'b0, mem_rden}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
